// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
//   ctrl_state_t : sequencer states (INIT, RUN, MEM_WAIT, HALT)
//   REG_ADDR_W   : default register-file address width (8 registers)
//   stage_ctrl_t : per-register control bundle {en, flush}
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 3;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic en;
        logic flush;
    } stage_ctrl_t;

    // Common per-stage control settings.
    localparam stage_ctrl_t STG_ADV    = '{en: 1'b1, flush: 1'b0};
    localparam stage_ctrl_t STG_HOLD   = '{en: 1'b0, flush: 1'b0};
    localparam stage_ctrl_t STG_BUBBLE = '{en: 1'b1, flush: 1'b1};

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use hazard comparator.
// Flags when the instruction in ID reads a register that the load
// currently in EX will write. Register 0 is treated like any other.
//   id_rs, id_rt            : source registers of the ID instruction
//   id_uses_rs, id_uses_rt  : which sources the ID instruction actually reads
//   ex_mem_read             : EX instruction is a load
//   ex_reg_write            : EX instruction writes a register
//   ex_reg_dst              : destination register of the EX instruction
//   load_use                : hazard present this cycle
module hazard_detect #(
    parameter int REG_ADDR_W = pipe_ctrl_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_reg_dst,
    output logic                  load_use
);

    logic rs_match;
    logic rt_match;

    assign rs_match = id_uses_rs && (id_rs == ex_reg_dst);
    assign rt_match = id_uses_rt && (id_rt == ex_reg_dst);
    assign load_use = ex_mem_read && ex_reg_write && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the 5-stage 16-bit pipeline.
// Drives advance enables and bubble flushes of the PC and the four
// inter-stage registers; handles load-use stalls, taken-branch flushes,
// multi-cycle RAM waits with a timeout halt, and counts stall cycles.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   id_rs/id_rt/id_uses_rs/id_uses_rt, ex_mem_read/ex_reg_write/ex_reg_dst
//                                   : load-use detection inputs
//   branch_taken                    : branch resolved taken in EX
//   mem_req, mem_ready              : RAM access handshake for MEM stage
//   pc_en, *_en, *_flush            : per-register advance / bubble controls
//   mem_timeout_err                 : sticky RAM timeout flag
//   stall_cycles                    : saturating count of stalled cycles
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = pipe_ctrl_pkg::REG_ADDR_W,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_reg_dst,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic                  mem_wb_flush,
    output logic                  mem_timeout_err,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_t       state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              err_set;
    logic              load_use;
    logic              mem_stall;

    logic              run_pc_en;
    stage_ctrl_t       run_if_id, run_id_ex, run_ex_mem, run_mem_wb;
    logic              pc_en_c;
    stage_ctrl_t       if_id_c, id_ex_c, ex_mem_c, mem_wb_c;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_reg_dst   (ex_reg_dst),
        .load_use     (load_use)
    );

    assign mem_stall = mem_req && !mem_ready;

    // Free-running pipeline controls: branch flush outranks load-use,
    // since the load-use victim in ID is being squashed anyway.
    always_comb begin
        run_pc_en  = 1'b1;
        run_if_id  = STG_ADV;
        run_id_ex  = STG_ADV;
        run_ex_mem = STG_ADV;
        run_mem_wb = STG_ADV;
        if (branch_taken) begin
            run_if_id = STG_BUBBLE;
            run_id_ex = STG_BUBBLE;
        end else if (load_use) begin
            run_pc_en = 1'b0;
            run_if_id = STG_HOLD;
            run_id_ex = STG_BUBBLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        err_set   = 1'b0;
        pc_en_c   = 1'b0;
        if_id_c   = STG_HOLD;
        id_ex_c   = STG_HOLD;
        ex_mem_c  = STG_HOLD;
        mem_wb_c  = STG_HOLD;
        unique case (state)
            INIT: begin
                if_id_c   = STG_BUBBLE;
                id_ex_c   = STG_BUBBLE;
                ex_mem_c  = STG_BUBBLE;
                mem_wb_c  = STG_BUBBLE;
                state_nxt = RUN;
            end
            RUN: begin
                if (mem_stall) begin
                    // Freeze everything up to MEM; let WB drain and
                    // feed it bubbles while RAM is busy.
                    mem_wb_c  = STG_BUBBLE;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end else begin
                    pc_en_c  = run_pc_en;
                    if_id_c  = run_if_id;
                    id_ex_c  = run_id_ex;
                    ex_mem_c = run_ex_mem;
                    mem_wb_c = run_mem_wb;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    // Completion wins over a coincident timeout.
                    pc_en_c   = run_pc_en;
                    if_id_c   = run_if_id;
                    id_ex_c   = run_id_ex;
                    ex_mem_c  = run_ex_mem;
                    mem_wb_c  = run_mem_wb;
                    state_nxt = RUN;
                end else begin
                    mem_wb_c = STG_BUBBLE;
                    if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                        state_nxt = HALT;
                        err_set   = 1'b1;
                    end else begin
                        wait_nxt = wait_cnt + 1'b1;
                    end
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    // A flush only takes effect on a register that is also loading.
    assign pc_en        = pc_en_c;
    assign if_id_en     = if_id_c.en;
    assign id_ex_en     = id_ex_c.en;
    assign ex_mem_en    = ex_mem_c.en;
    assign mem_wb_en    = mem_wb_c.en;
    assign if_id_flush  = if_id_c.en  & if_id_c.flush;
    assign id_ex_flush  = id_ex_c.en  & id_ex_c.flush;
    assign ex_mem_flush = ex_mem_c.en & ex_mem_c.flush;
    assign mem_wb_flush = mem_wb_c.en & mem_wb_c.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_timeout_err <= 1'b0;
        end else if (err_set) begin
            mem_timeout_err <= 1'b1;
        end
    end

    // Only stalls of a live pipeline count; INIT and HALT are excluded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if ((state == RUN || state == MEM_WAIT) && !pc_en_c
                     && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
// Output vector order: {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
//                       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}
module tb_pipeline_hazard_ctrl;

    localparam logic [8:0] O_INIT   = 9'b0_1111_1111;
    localparam logic [8:0] O_RUN    = 9'b1_1111_0000;
    localparam logic [8:0] O_LU     = 9'b0_0111_0100;
    localparam logic [8:0] O_BR     = 9'b1_1111_1100;
    localparam logic [8:0] O_FREEZE = 9'b0_0001_0001;
    localparam logic [8:0] O_HALT   = 9'b0_0000_0000;
    localparam int         STALL_MAX = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] id_rs, id_rt, ex_reg_dst;
    logic       id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write;
    logic       branch_taken, mem_req, mem_ready;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic       mem_timeout_err;
    logic [3:0] stall_cycles;
    logic [8:0] out9;

    int n_checks = 0;
    int n_errors = 0;
    int exp_stall = 0;

    typedef struct {
        string      name;
        logic [2:0] rs, rt, dst;
        logic       urs, urt, mr, rw, br, mreq, mrdy;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W  (3),
        .MEM_TIMEOUT (4),
        .CNT_W       (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_reg_write    (ex_reg_write),
        .ex_reg_dst      (ex_reg_dst),
        .branch_taken    (branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_flush    (ex_mem_flush),
        .mem_wb_flush    (mem_wb_flush),
        .mem_timeout_err (mem_timeout_err),
        .stall_cycles    (stall_cycles)
    );

    assign out9 = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                   if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

    task automatic add_vec(input string n, input logic [2:0] rs, input logic [2:0] rt,
                           input logic urs, input logic urt, input logic mr, input logic rw,
                           input logic [2:0] dst, input logic br, input logic mreq,
                           input logic mrdy, input logic [8:0] exp);
        vec_t v;
        v.name = n; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
        v.mr = mr; v.rw = rw; v.dst = dst; v.br = br; v.mreq = mreq;
        v.mrdy = mrdy; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [2:0] rs, input logic [2:0] rt, input logic urs,
                         input logic urt, input logic mr, input logic rw,
                         input logic [2:0] dst, input logic br, input logic mreq,
                         input logic mrdy);
        id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        ex_mem_read = mr; ex_reg_write = rw; ex_reg_dst = dst;
        branch_taken = br; mem_req = mreq; mem_ready = mrdy;
    endtask

    task automatic idle();
        drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_out(input string nm, input logic [8:0] exp);
        n_checks++;
        if (out9 !== exp) begin
            n_errors++;
            $display("FAIL %s: controls got %b expected %b", nm, out9, exp);
        end
    endtask

    task automatic chk_val(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Advance to the next cycle's drive point (1 ns after the rising edge).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic count_stall(input logic [8:0] exp);
        if (!exp[8]) exp_stall = (exp_stall == STALL_MAX) ? STALL_MAX : exp_stall + 1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();

        add_vec("idle",          3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 0, 0, O_RUN);
        add_vec("lu_rs",         3'd3, 3'd0, 1, 0, 1, 1, 3'd3, 0, 0, 0, O_LU);
        add_vec("lu_rs_unused",  3'd3, 3'd0, 0, 0, 1, 1, 3'd3, 0, 0, 0, O_RUN);
        add_vec("lu_rt",         3'd0, 3'd5, 0, 1, 1, 1, 3'd5, 0, 0, 0, O_LU);
        add_vec("match_unused",  3'd5, 3'd5, 0, 0, 1, 1, 3'd5, 0, 0, 0, O_RUN);
        add_vec("lu_reg0",       3'd0, 3'd7, 1, 0, 1, 1, 3'd0, 0, 0, 0, O_LU);
        add_vec("no_reg_write",  3'd3, 3'd3, 1, 1, 1, 0, 3'd3, 0, 0, 0, O_RUN);
        add_vec("not_load",      3'd3, 3'd3, 1, 1, 0, 1, 3'd3, 0, 0, 0, O_RUN);
        add_vec("branch_and_lu", 3'd3, 3'd0, 1, 0, 1, 1, 3'd3, 1, 0, 0, O_BR);
        add_vec("branch_only",   3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 1, 0, 0, O_BR);
        add_vec("mem_fast",      3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 1, 1, O_RUN);
        add_vec("mem_fast_lu",   3'd4, 3'd0, 1, 0, 1, 1, 3'd4, 0, 1, 1, O_LU);
        add_vec("no_match",      3'd3, 3'd4, 1, 1, 1, 1, 3'd2, 0, 0, 0, O_RUN);

        // Reset and release
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_out("reset_held", O_INIT);
        chk_val("reset_stall", int'(stall_cycles), 0);
        chk_val("reset_err", int'(mem_timeout_err), 0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk_out("init_cycle", O_INIT);
        next_cycle();
        @(negedge clk);
        chk_out("run_after_init", O_RUN);
        chk_val("stall_after_init", int'(stall_cycles), 0);

        // Single-cycle RUN vectors
        foreach (vecs[i]) begin
            next_cycle();
            drive(vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt, vecs[i].mr,
                  vecs[i].rw, vecs[i].dst, vecs[i].br, vecs[i].mreq, vecs[i].mrdy);
            @(negedge clk);
            chk_out(vecs[i].name, vecs[i].exp);
            count_stall(vecs[i].exp);
        end
        next_cycle();
        idle();
        @(negedge clk);
        chk_val("stall_after_table", int'(stall_cycles), exp_stall);

        // RAM wait: three frozen cycles, release on the fourth
        next_cycle();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk_out($sformatf("ram_wait_c%0d", c), O_FREEZE);
            count_stall(O_FREEZE);
            next_cycle();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk_out("ram_release", O_RUN);
        next_cycle();
        idle();
        @(negedge clk);
        chk_out("ram_after", O_RUN);
        chk_val("ram_stall", int'(stall_cycles), exp_stall);

        // mem_ready on the timeout cycle wins; branch evaluated that cycle
        next_cycle();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk_out($sformatf("edge_wait_c%0d", c), O_FREEZE);
            count_stall(O_FREEZE);
            next_cycle();
        end
        mem_ready = 1'b1; branch_taken = 1'b1;
        @(negedge clk);
        chk_out("edge_ready_wins", O_BR);
        next_cycle();
        idle();
        @(negedge clk);
        chk_out("edge_back_run", O_RUN);
        chk_val("edge_err", int'(mem_timeout_err), 0);
        chk_val("edge_stall", int'(stall_cycles), exp_stall);

        // Counter saturation: 20 load-use stalls
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            drive(3'd6, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            count_stall(O_LU);
        end
        chk_out("sat_lu", O_LU);
        next_cycle();
        idle();
        @(negedge clk);
        chk_val("sat_stall", int'(stall_cycles), STALL_MAX);

        // Timeout to HALT, then reset clears
        next_cycle();
        rst_n = 1'b0;
        #1;
        chk_val("to_reset_stall", int'(stall_cycles), 0);
        next_cycle();
        rst_n = 1'b1;
        exp_stall = 0;
        next_cycle();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk_out($sformatf("to_wait_c%0d", c), O_FREEZE);
            count_stall(O_FREEZE);
            next_cycle();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk_out("halt_outputs", O_HALT);
        chk_val("halt_err", int'(mem_timeout_err), 1);
        chk_val("halt_stall", int'(stall_cycles), exp_stall);
        next_cycle();
        @(negedge clk);
        chk_out("halt_sticky", O_HALT);
        #1;
        rst_n = 1'b0;
        idle();
        #1;
        chk_out("halt_reset_out", O_INIT);
        chk_val("halt_reset_err", int'(mem_timeout_err), 0);
        chk_val("halt_reset_stall", int'(stall_cycles), 0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk_out("halt_reinit", O_INIT);
        next_cycle();
        @(negedge clk);
        chk_out("halt_rerun", O_RUN);

        // Reset asserted mid-MEM_WAIT
        next_cycle();
        mem_req = 1'b1; mem_ready = 1'b0;
        next_cycle();
        @(negedge clk);
        chk_out("midwait_frozen", O_FREEZE);
        #1;
        rst_n = 1'b0;
        #1;
        chk_out("midwait_reset_out", O_INIT);
        chk_val("midwait_reset_stall", int'(stall_cycles), 0);
        next_cycle();
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        chk_out("midwait_init", O_INIT);
        next_cycle();
        @(negedge clk);
        chk_out("midwait_run", O_RUN);
        chk_val("midwait_stall", int'(stall_cycles), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage 16-bit pipeline.
- Each cycle it drives the advance-enable and bubble-flush inputs of the PC and the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Handles load-use stalls, taken-branch flushes and multi-cycle RAM waits, with a timeout halt and a stall-cycle counter.
- Instantiated once at processor top level, beside the pipeline registers.

Parameters:
REG_ADDR_W, 3, register-file address width (8 registers)
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before HALT (must be >=1)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
id_rs  in  REG_ADDR_W  source reg A of instruction in ID
id_rt  in  REG_ADDR_W  source reg B of instruction in ID
id_uses_rs  in  1  ID instruction reads id_rs
id_uses_rt  in  1  ID instruction reads id_rt
ex_mem_read  in  1  instruction in EX is a load (mem_to_reg)
ex_reg_write  in  1  instruction in EX writes a register
ex_reg_dst  in  REG_ADDR_W  destination reg of EX instruction
branch_taken  in  1  branch resolved taken in EX
mem_req  in  1  instruction in MEM accesses RAM
mem_ready  in  1  RAM completes access this cycle
pc_en  out  1  PC update enable
if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register advance enables
if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load bubble (all-zero controls) when enabled
mem_timeout_err  out  1  sticky RAM timeout flag
stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0 in RUN/MEM_WAIT

Behaviour:
- States: INIT, RUN, MEM_WAIT, HALT. rst_n low -> state INIT, wait_cnt=0, stall_cycles=0, mem_timeout_err=0.
- Outputs are Mealy (state + current inputs). Flush applies only where the matching en=1.
- INIT (one cycle after rst_n rises): all *_en=1, all *_flush=1, pc_en=0. Next state RUN. While rst_n low, outputs equal INIT values.
- RUN defaults: all en=1, all flush=0. Overrides are evaluated in priority order below.
- RUN, priority 1 (mem_req && !mem_ready): pc_en=if_id_en=id_ex_en=ex_mem_en=0; mem_wb_en=1 with mem_wb_flush=1. Next state MEM_WAIT; wait_cnt<=1. Branch/load-use are ignored this cycle because EX is frozen.
- RUN, priority 2 (branch_taken): if_id_flush=id_ex_flush=1, all en=1 (PC loads target). A simultaneous load-use hazard is ignored.
- RUN, priority 3 (load-use): ex_mem_read && ex_reg_write && ((id_uses_rs && id_rs==ex_reg_dst) || (id_uses_rt && id_rt==ex_reg_dst)) -> pc_en=if_id_en=0, id_ex_flush=1. Exactly one bubble per hazard; no state change.
- MEM_WAIT: same freeze outputs as priority 1.
  - mem_ready=1 -> RUN-default outputs this cycle (priority 2/3 are evaluated with current inputs); next state RUN.
  - Else if wait_cnt==MEM_TIMEOUT -> next state HALT, mem_timeout_err<=1.
  - Else wait_cnt++.
  - mem_ready in the same cycle as the timeout: mem_ready wins.
- HALT: all en=0, all flush=0; exits only via reset.
- stall_cycles increments on every cycle in RUN or MEM_WAIT with pc_en=0; holds at 2^CNT_W-1.
- Register 0 is an ordinary register here; no zero-register exemption.
- Reset asserted mid-MEM_WAIT: immediate return to INIT values; counters cleared.

Decomposition:
- Shared package pipe_ctrl_pkg: state enum (INIT, RUN, MEM_WAIT, HALT), REG_ADDR_W constant, and a stage-control bundle type {en, flush}.
- One sub-module, hazard_detect: the combinational load-use comparator, reused later by a forwarding unit. The FSM and counters stay in the top.

Test Plan:
- Reset release: rst_n 0->1 -> one cycle with pc_en=0 and all flush=1, then all en=1, all flush=0; stall_cycles=0.
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_reg_dst=3, id_rs=3, id_uses_rs=1 -> single cycle pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles=1. Same with id_uses_rs=0 -> no stall.
- Branch and load-use together: branch_taken=1 with the hazard above -> if_id_flush=id_ex_flush=1, pc_en=1; stall_cycles unchanged.
- RAM wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> 3 frozen cycles with mem_wb_flush=1, release on the 4th cycle; stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> HALT after 5 frozen cycles, mem_timeout_err=1, all en=0. rst_n pulse clears the flag and returns to INIT.
- Counter saturation: CNT_W=4, 20 load-use stalls -> stall_cycles stops at 15.
